// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the CORDIC blocks.
// Angles are Q4.28 radians; the inverse CORDIC gain is Q0.16.
package cordic_pkg;

   localparam logic signed [31:0] PI_Q28       = 32'sd843314857;
   localparam logic signed [31:0] HALF_PI_Q28  = 32'sd421657428;
   localparam logic signed [31:0] INV_GAIN_Q16 = 32'sd39797;

   // atan(2^-i) in Q4.28 for i = 0..27; entries 28..31 pad the 5-bit index space.
   localparam logic [31:0] ATAN_Q28 [32] = '{
      32'd210828714, 32'd124459457, 32'd65760959,  32'd33381289,
      32'd16755421,  32'd8385878,   32'd4193962,   32'd2097109,
      32'd1048570,   32'd524287,    32'd262143,    32'd131071,
      32'd65535,     32'd32767,     32'd16383,     32'd8191,
      32'd4095,      32'd2047,      32'd1023,      32'd511,
      32'd255,       32'd127,       32'd63,        32'd31,
      32'd15,        32'd7,         32'd3,         32'd1,
      32'd0,         32'd0,         32'd0,         32'd0
   };

   typedef enum logic [1:0] {
      IDLE,
      ROTATE,
      SCALE,
      DONE
   } cordic_state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Iteration index to Q4.28 arctangent lookup, shared by the CORDIC rotation blocks.
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [4:0]  idx,
   output logic [31:0] atan_q28
);

   assign atan_q28 = ATAN_Q28[idx];

endmodule

// File: rtl/cordic_polar2rect.sv
// Iterative CORDIC polar-to-rectangular converter: one micro-rotation per clock,
// followed by a gain-correction/rounding/saturation step.
module cordic_polar2rect
   import cordic_pkg::*;
#(
   parameter int OUTPUT_WIDTH    = 16,
   parameter int INT_WIDTH       = 32,
   parameter int ITERATIONS      = 16,
   parameter int INPUT_FRAC_BITS = 14
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic signed [INT_WIDTH-1:0]    magnitude,
   input  logic signed [INT_WIDTH-1:0]    phase,
   output logic                           busy,
   output logic                           done,
   output logic signed [OUTPUT_WIDTH-1:0] x_out,
   output logic signed [OUTPUT_WIDTH-1:0] y_out
);

   localparam int XW    = INT_WIDTH + 2;
   localparam int CW    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam int SHIFT = 16 + INPUT_FRAC_BITS;
   localparam int PW    = XW + 18;

   localparam logic [CW-1:0]           LAST      = CW'(ITERATIONS - 1);
   localparam logic signed [INT_WIDTH-1:0] PI_I   = INT_WIDTH'(PI_Q28);
   localparam logic signed [INT_WIDTH-1:0] HALF_I = INT_WIDTH'(HALF_PI_Q28);
   localparam logic signed [PW-1:0]    GAIN      = PW'(INV_GAIN_Q16);
   localparam logic signed [PW-1:0]    ROUND_ADD = PW'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [PW-1:0]    OUT_MAX   = PW'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [PW-1:0]    OUT_MIN   = ~OUT_MAX;

   cordic_state_t state, next_state;

   logic                        load, step, scale_en, busy_d, done_d;
   logic signed [XW-1:0]        x, y, x0, mag_ext, x_sh, y_sh;
   logic signed [INT_WIDTH-1:0] z, z0, atan_z;
   logic [CW-1:0]               cnt;
   logic [31:0]                 atan_q28;
   logic signed [PW-1:0]        x_rnd, y_rnd;

   function automatic logic signed [OUTPUT_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
      if (v > OUT_MAX)
         return {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      else if (v < OUT_MIN)
         return {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
      else
         return v[OUTPUT_WIDTH-1:0];
   endfunction

   cordic_atan_lut u_atan_lut (
      .idx      (5'(cnt)),
      .atan_q28 (atan_q28)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = ROTATE;
         ROTATE:  if (cnt == LAST) next_state = SCALE;
         SCALE:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load     = (state == IDLE) && start;
      step     = (state == ROTATE);
      scale_en = (state == SCALE);
      busy_d   = (state == ROTATE) || (state == SCALE);
      done_d   = (state == DONE);
   end

   // Status flags are registered, so they trail the state by one cycle:
   // busy rises the cycle after capture and done shows while the FSM is back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
      end
   end

   // Fold the angle into [-pi/2, pi/2]; a half-turn is the same as negating the radius.
   always_comb begin
      mag_ext = XW'(magnitude);
      x0      = mag_ext;
      z0      = phase;
      if (phase > HALF_I) begin
         x0 = -mag_ext;
         z0 = phase - PI_I;
      end else if (phase < -HALF_I) begin
         x0 = -mag_ext;
         z0 = phase + PI_I;
      end
   end

   assign x_sh   = x >>> cnt;
   assign y_sh   = y >>> cnt;
   assign atan_z = INT_WIDTH'(atan_q28);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x   <= '0;
         y   <= '0;
         z   <= '0;
         cnt <= '0;
      end else if (load) begin
         x   <= x0;
         y   <= '0;
         z   <= z0;
         cnt <= '0;
      end else if (step) begin
         if (!z[INT_WIDTH-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_z;
         end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_z;
         end
         if (cnt != LAST)
            cnt <= cnt + 1'b1;
      end
   end

   assign x_rnd = ((PW'(x) * GAIN) + ROUND_ADD) >>> SHIFT;
   assign y_rnd = ((PW'(y) * GAIN) + ROUND_ADD) >>> SHIFT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_out <= '0;
         y_out <= '0;
      end else if (scale_en) begin
         x_out <= sat(x_rnd);
         y_out <= sat(y_rnd);
      end
   end

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Self-checking bench for cordic_polar2rect: directed vector table, randomized
// conversions against a floating-point trigonometric model, and handshake corners.
module tb_cordic_polar2rect;

   localparam int ITER = 16;
   localparam int LAT  = ITER + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic signed [31:0] magnitude = '0;
   logic signed [31:0] phase = '0;
   logic        busy, done;
   logic signed [15:0] x_out, y_out;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int mag;
      int ph;
      int ex;
      int ey;
      int tx;
      int ty;
   } vec_t;

   vec_t vecs [13];

   cordic_polar2rect #(
      .OUTPUT_WIDTH    (16),
      .INT_WIDTH       (32),
      .ITERATIONS      (ITER),
      .INPUT_FRAC_BITS (14)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .magnitude (magnitude),
      .phase     (phase),
      .busy      (busy),
      .done      (done),
      .x_out     (x_out),
      .y_out     (y_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp, input int tol);
      int diff;
      n_cmp++;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (+/- %0d)", name, act, exp, tol);
      end
   endtask

   // Ideal result: round-half-up of r*cos/sin, clamped to the 16-bit output range.
   function automatic int ref_axis(input int mag, input int ph, input bit is_sin);
      real r, a, v;
      r = real'(mag) / 16384.0;
      a = real'(ph) / 268435456.0;
      v = is_sin ? r * $sin(a) : r * $cos(a);
      v = $floor(v + 0.5);
      if (v > 32767.0) v = 32767.0;
      if (v < -32768.0) v = -32768.0;
      return $rtoi(v);
   endfunction

   task automatic run_conv(input int mag, input int ph, output int xo, output int yo);
      int lat;
      bit prof_ok;
      @(negedge clk);
      start = 1'b1;
      magnitude = mag;
      phase = ph;
      @(posedge clk);
      #1;
      start = 1'b0;
      magnitude = $urandom;
      phase = $urandom;
      check("flags_at_capture", int'({busy, done}), 0, 0);
      prof_ok = 1'b1;
      lat = -1;
      for (int k = 1; k <= LAT + 20; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (busy) prof_ok = 1'b0;
            lat = k;
            break;
         end
         if (!busy) prof_ok = 1'b0;
      end
      check("busy_profile", int'(prof_ok), 1, 0);
      check("latency", lat, LAT, 0);
      xo = x_out;
      yo = y_out;
   endtask

   initial begin
      int xo, yo, xa, ya, mag, ph, n_done, done_k;

      vecs[0]  = '{23170476, 210828714, 1000, 1000, 1, 1};
      vecs[1]  = '{23170476, 632486143, -1000, 1000, 1, 1};
      vecs[2]  = '{23170476, -632486143, -1000, -1000, 1, 1};
      vecs[3]  = '{23170476, -210828714, 1000, -1000, 1, 1};
      vecs[4]  = '{16384000, 421657428, 0, 1000, 1, 1};
      vecs[5]  = '{16384000, 0, 1000, 0, 1, 1};
      vecs[6]  = '{655360000, 0, 32767, 0, 0, 2};
      vecs[7]  = '{0, 300000000, 0, 0, 0, 0};
      vecs[8]  = '{-16384000, 210828714, -707, -707, 1, 1};
      vecs[9]  = '{-655360000, 0, -32768, 0, 0, 2};
      vecs[10] = '{16384000, 843314857, -1000, 0, 1, 1};
      vecs[11] = '{16384000, -843314857, -1000, 0, 1, 1};
      vecs[12] = '{16384000, -421657428, 0, -1000, 1, 1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", int'(busy), 0, 0);
      check("reset_done", int'(done), 0, 0);
      check("reset_x", int'(x_out), 0, 0);
      check("reset_y", int'(y_out), 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_conv(vecs[i].mag, vecs[i].ph, xo, yo);
         check($sformatf("vec%0d_x", i), xo, vecs[i].ex, vecs[i].tx);
         check($sformatf("vec%0d_y", i), yo, vecs[i].ey, vecs[i].ty);
      end

      repeat (5) @(posedge clk);
      #1;
      check("hold_x", int'(x_out), vecs[12].ex, vecs[12].tx);
      check("hold_y", int'(y_out), vecs[12].ey, vecs[12].ty);
      check("hold_done", int'(done), 0, 0);

      for (int n = 0; n < 20; n++) begin
         mag = int'($urandom_range(0, 655360000)) - 327680000;
         ph = int'($urandom_range(0, 1686629714)) - 843314857;
         run_conv(mag, ph, xo, yo);
         check("rand_x", xo, ref_axis(mag, ph, 1'b0), 2);
         check("rand_y", yo, ref_axis(mag, ph, 1'b1), 2);
      end

      // Extra start pulses mid-conversion with different inputs must be ignored.
      @(negedge clk);
      start = 1'b1;
      magnitude = 23170476;
      phase = 210828714;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_done = 0;
      done_k = -1;
      xa = 0;
      ya = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = (k == 3) || (k == 10);
         magnitude = 16384000;
         phase = -421657428;
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            done_k = k;
            xa = x_out;
            ya = y_out;
         end
      end
      start = 1'b0;
      check("restart_done_count", n_done, 1, 0);
      check("restart_done_cycle", done_k, LAT, 0);
      check("restart_x", xa, 1000, 1);
      check("restart_y", ya, 1000, 1);

      // Reset in the middle of a conversion aborts it with no done pulse.
      @(negedge clk);
      start = 1'b1;
      magnitude = 16384000;
      phase = 421657428;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0, 0);
      check("abort_done", int'(done), 0, 0);
      check("abort_x", int'(x_out), 0, 0);
      check("abort_y", int'(y_out), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) n_done++;
      end
      check("abort_no_activity", n_done, 0, 0);
      run_conv(23170476, -632486143, xo, yo);
      check("post_abort_x", xo, -1000, 1);
      check("post_abort_y", yo, -1000, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cordic_polar2rect.md
CORDIC_POLAR2RECT -- requirements
Module: cordic_polar2rect

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 16, the signed width of x_out/y_out in integer units.
REQ-002 Parameter INT_WIDTH, default 32, the signed width of magnitude, phase and the internal datapath before guard bits.
REQ-003 Parameter ITERATIONS, default 16, the number of CORDIC micro-rotations (range 1..28).
REQ-004 Parameter INPUT_FRAC_BITS, default 14, the number of fractional bits of magnitude.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, requests a conversion; sampled on a rising edge while the block is idle.
REQ-008 Port magnitude, input, INT_WIDTH, signed radius with INPUT_FRAC_BITS fractional bits.
REQ-009 Port phase, input, INT_WIDTH, signed angle in radians scaled by 2^28 (Q4.28); the valid range is [-pi, +pi].
REQ-010 Port busy, output, 1, high while a conversion is in progress.
REQ-011 Port done, output, 1, a one-cycle pulse that marks new x_out/y_out.
REQ-012 Ports x_out and y_out, output, OUTPUT_WIDTH each, signed round(magnitude*cos(phase)) and round(magnitude*sin(phase)) in integer units.

Function
REQ-013 FSM states: IDLE, ROTATE, SCALE, DONE; reset state IDLE.
REQ-014 IDLE with start=1 at edge E0: capture inputs, apply quadrant pre-rotation, clear the iteration counter, enter ROTATE, set busy=1.
REQ-015 Pre-rotation: if phase > pi/2, x0=-magnitude, y0=0, z0=phase-pi; if phase < -pi/2, x0=-magnitude, z0=phase+pi; otherwise x0=magnitude, y0=0, z0=phase.
REQ-016 ROTATE, iteration i (0..ITERATIONS-1), d=+1 when z>=0, else -1: x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*atan(2^-i); one iteration per clock.
REQ-017 After iteration ITERATIONS-1, enter SCALE; the counter never exceeds ITERATIONS-1.
REQ-018 SCALE: multiply x and y by the inverse-gain constant 39797 (Q0.16); arithmetic shift right by 16+INPUT_FRAC_BITS, rounding half up (add 2^(shift-1) first).
REQ-019 SCALE: saturate each result to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]; register it into x_out/y_out; enter DONE.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-021 done rises at edge E0+ITERATIONS+2, so the latency is ITERATIONS+2 cycles.
REQ-022 busy is high from E0+1 until done rises; busy and done are never high together.
REQ-023 Back-to-back operation: start is accepted again in the IDLE cycle after DONE; start during ROTATE, SCALE or DONE is ignored without side effect.
REQ-024 x_out/y_out hold their last value between completions; input changes after E0 have no effect on the current result.
REQ-025 x/y datapath width is INT_WIDTH+2 (two guard bits absorb CORDIC gain 1.647); the z datapath is INT_WIDTH.
REQ-026 magnitude=0 gives x_out=y_out=0; a negative magnitude gives the negated vector; a phase outside [-pi, pi] still completes with the normal latency, with an unspecified value.

Reset
REQ-027 rst_n low, asserted at any time including mid-conversion: state=IDLE, busy=0, done=0, x_out=0, y_out=0, counter=0, internal x/y/z=0, with no done pulse for the aborted conversion.
REQ-028 The first start is accepted on the first rising edge with rst_n high.

Structure
REQ-029 Shared package cordic_pkg holds: PI_Q28=843314857, HALF_PI_Q28=421657428, INV_GAIN_Q16=39797, the Q4.28 arctangent table for i=0..27 (atan(1)=210828714), and the FSM state typedef.
REQ-030 One sub-module, cordic_atan_lut, maps the iteration index to the Q4.28 arctangent; it is shared with the magnitude/phase block.

Verification
REQ-031 magnitude=23170476 (1414.2136*2^14), phase=210828714 (pi/4) -> x_out=1000+/-1, y_out=1000+/-1, done 18 cycles after start.
REQ-032 Same magnitude, phase=632486143 (3pi/4) -> (-1000, 1000)+/-1; phase=-632486143 -> (-1000, -1000)+/-1; phase=-210828714 -> (1000, -1000)+/-1.
REQ-033 magnitude=16384000 (1000.0), phase=421657428 (pi/2) -> (0, 1000)+/-1; phase=0 -> (1000, 0)+/-1.
REQ-034 magnitude=655360000 (40000.0), phase=0 -> x_out=32767 (saturated), y_out=0.
REQ-035 start pulsed again at cycles 3 and 10 of a conversion with different inputs -> exactly one done, result of the first inputs.
REQ-036 rst_n low at cycle 8 of a conversion -> busy=0, done=0, outputs 0 immediately, no done after release; the next start completes normally.
